// File: rtl/factorial_pkg.sv
// factorial_pkg: shared types and constants for the factorial core requester.
//   - fact_req_state_e : requester FSM state encoding
//   - *_DEF            : default parameter values for factorial_requester
//   - FACT_TABLE       : reference results 0!..7! used by the optional result checker
package factorial_pkg;

  localparam int unsigned IN_DATA_WD_DEF     = 3;
  localparam int unsigned OUT_DATA_WD_DEF    = 16;
  localparam int unsigned FIFO_DEPTH_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  localparam int unsigned FACT_TABLE_WD      = 16;
  localparam int unsigned FACT_TABLE_ENTRIES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fact_req_state_e;

  // n! for n = 0..7; 7! = 5040 needs 13 bits, stored at 16.
  localparam logic [FACT_TABLE_WD-1:0] FACT_TABLE [FACT_TABLE_ENTRIES] = '{
    16'd1, 16'd1, 16'd2, 16'd6, 16'd24, 16'd120, 16'd720, 16'd5040
  };

endpackage : factorial_pkg

// File: rtl/fact_req_fifo.sv
// fact_req_fifo: synchronous FIFO with count-based full/empty flags.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   head_data         : entry at the read pointer (valid when !empty)
//   full, empty       : decoded from the registered occupancy count
// DEPTH must be a power of two so the pointers wrap naturally.
module fact_req_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule : fact_req_fifo

// File: rtl/factorial_requester.sv
// factorial_requester: queues operands from a command port and issues them one
// at a time to the factorial core, returning each result (or a timeout) tagged
// with its operand on a valid/ready response port.
// Ports:
//   clk, resetn                   : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_data  : upstream operand port (cmd_ready = FIFO not full)
//   fact_in_data/fact_in_valid    : request to the core (one-cycle pulse)
//   fact_out_data/fact_out_valid  : result from the core (one-cycle pulse)
//   fact_out_busy                 : core busy; blocks new requests
//   rsp_valid/rsp_ready           : response handshake
//   rsp_data/rsp_operand          : result (0 on timeout) and its operand
//   rsp_timeout                   : response is a timeout
//   rsp_mismatch                  : result differs from n! (only with FACT_REQ_CHECK_EN)
//   err_spurious                  : sticky, result pulse seen outside WAIT
// Build option: define FACT_REQ_CHECK_EN to add the rsp_mismatch result checker.
module factorial_requester
  import factorial_pkg::*;
#(
  parameter int unsigned IN_DATA_WD     = IN_DATA_WD_DEF,
  parameter int unsigned OUT_DATA_WD    = OUT_DATA_WD_DEF,
  parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IN_DATA_WD-1:0]  cmd_data,
  output logic [IN_DATA_WD-1:0]  fact_in_data,
  output logic                   fact_in_valid,
  input  logic [OUT_DATA_WD-1:0] fact_out_data,
  input  logic                   fact_out_valid,
  input  logic                   fact_out_busy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OUT_DATA_WD-1:0] rsp_data,
  output logic [IN_DATA_WD-1:0]  rsp_operand,
  output logic                   rsp_timeout,
`ifdef FACT_REQ_CHECK_EN
  output logic                   rsp_mismatch,
`endif
  output logic                   err_spurious
);

  localparam int unsigned TMO_WD = $clog2(TIMEOUT_CYCLES + 1);

`ifdef FACT_REQ_CHECK_EN
  // The reference table only covers 3-bit operands with results up to 13 bits.
  if (IN_DATA_WD != 3 || OUT_DATA_WD < 13) begin : g_check_cfg_bad
    $error("factorial_requester: checker needs IN_DATA_WD==3 and OUT_DATA_WD>=13");
  end
`endif

  fact_req_state_e        state_q;
  fact_req_state_e        state_d;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [IN_DATA_WD-1:0]  fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic [TMO_WD-1:0]      tmo_cnt_q;
  logic [TMO_WD-1:0]      tmo_cnt_d;
  logic                   tmo_hit_c;

  logic                   fact_in_valid_d;
  logic [IN_DATA_WD-1:0]  fact_in_data_d;
  logic                   rsp_valid_d;
  logic [OUT_DATA_WD-1:0] rsp_data_d;
  logic [IN_DATA_WD-1:0]  rsp_operand_d;
  logic                   rsp_timeout_d;
  logic                   err_spurious_d;

`ifdef FACT_REQ_CHECK_EN
  logic                   rsp_mismatch_d;
  logic                   result_mismatch_c;

  // fact_in_data holds the operand of the in-flight request during WAIT.
  assign result_mismatch_c = (fact_out_data != OUT_DATA_WD'(FACT_TABLE[fact_in_data]));
`endif

  // cmd_ready is the only combinational output; a same-cycle pop does not relax it.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  fact_req_fifo #(
    .WIDTH (IN_DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (fifo_push),
    .push_data (cmd_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Counter holds the number of completed WAIT cycles; the limit is reached
  // in the WAIT cycle that makes it TIMEOUT_CYCLES.
  assign tmo_hit_c = (tmo_cnt_q == TMO_WD'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !fact_out_busy) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (fact_out_valid || tmo_hit_c) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered outputs, FIFO pop and counter.
  always_comb begin
    fact_in_valid_d = 1'b0;
    fact_in_data_d  = fact_in_data;
    rsp_valid_d     = (state_d == ST_RESP);
    rsp_data_d      = rsp_data;
    rsp_operand_d   = rsp_operand;
    rsp_timeout_d   = rsp_timeout;
    err_spurious_d  = err_spurious || (fact_out_valid && (state_q != ST_WAIT));
    tmo_cnt_d       = tmo_cnt_q;
    fifo_pop        = 1'b0;
`ifdef FACT_REQ_CHECK_EN
    rsp_mismatch_d  = rsp_mismatch;
`endif
    case (state_q)
      ST_IDLE: begin
        // Request goes out in the ISSUE cycle; head doubles as operand register.
        if (state_d == ST_ISSUE) begin
          fact_in_valid_d = 1'b1;
          fact_in_data_d  = fifo_head;
        end
      end
      ST_ISSUE: begin
        fifo_pop  = 1'b1;
        tmo_cnt_d = '0;
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + TMO_WD'(1);
        // A result arriving on the timeout cycle takes priority.
        if (fact_out_valid) begin
          rsp_data_d     = fact_out_data;
          rsp_operand_d  = fact_in_data;
          rsp_timeout_d  = 1'b0;
`ifdef FACT_REQ_CHECK_EN
          rsp_mismatch_d = result_mismatch_c;
`endif
        end else if (tmo_hit_c) begin
          rsp_data_d     = '0;
          rsp_operand_d  = fact_in_data;
          rsp_timeout_d  = 1'b1;
`ifdef FACT_REQ_CHECK_EN
          rsp_mismatch_d = 1'b0;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fact_in_valid <= 1'b0;
      fact_in_data  <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_operand   <= '0;
      rsp_timeout   <= 1'b0;
      err_spurious  <= 1'b0;
      tmo_cnt_q     <= '0;
`ifdef FACT_REQ_CHECK_EN
      rsp_mismatch  <= 1'b0;
`endif
    end else begin
      fact_in_valid <= fact_in_valid_d;
      fact_in_data  <= fact_in_data_d;
      rsp_valid     <= rsp_valid_d;
      rsp_data      <= rsp_data_d;
      rsp_operand   <= rsp_operand_d;
      rsp_timeout   <= rsp_timeout_d;
      err_spurious  <= err_spurious_d;
      tmo_cnt_q     <= tmo_cnt_d;
`ifdef FACT_REQ_CHECK_EN
      rsp_mismatch  <= rsp_mismatch_d;
`endif
    end
  end

endmodule : factorial_requester

// File: tb/tb_factorial_requester.sv
// tb_factorial_requester: directed, table-driven bench for factorial_requester
// with a small behavioural factorial core (configurable latency and answer).
module tb_factorial_requester;

  localparam int unsigned IN_WD  = 3;
  localparam int unsigned OUT_WD = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TMO    = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [IN_WD-1:0]  cmd_data = '0;
  logic [IN_WD-1:0]  fact_in_data;
  logic              fact_in_valid;
  logic [OUT_WD-1:0] fact_out_data;
  logic              fact_out_valid;
  logic              fact_out_busy = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [OUT_WD-1:0] rsp_data;
  logic [IN_WD-1:0]  rsp_operand;
  logic              rsp_timeout;
  logic              err_spurious;
`ifdef FACT_REQ_CHECK_EN
  logic              rsp_mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  factorial_requester #(
    .IN_DATA_WD     (IN_WD),
    .OUT_DATA_WD    (OUT_WD),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .fact_in_data   (fact_in_data),
    .fact_in_valid  (fact_in_valid),
    .fact_out_data  (fact_out_data),
    .fact_out_valid (fact_out_valid),
    .fact_out_busy  (fact_out_busy),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_operand    (rsp_operand),
    .rsp_timeout    (rsp_timeout),
`ifdef FACT_REQ_CHECK_EN
    .rsp_mismatch   (rsp_mismatch),
`endif
    .err_spurious   (err_spurious)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fact_fn(input logic [2:0] n);
    logic [15:0] r;
    r = 16'd1;
    for (int i = 2; i <= 32'(n); i++) begin
      r = r * 16'(i);
    end
    return r;
  endfunction

  // Behavioural core: answers core_lat cycles after seeing a request.
  int                core_lat = 1;
  logic              core_en = 1'b1;
  logic              core_override = 1'b0;
  logic [OUT_WD-1:0] core_val = '0;
  logic              core_pend = 1'b0;
  int                core_cnt = 0;
  logic [IN_WD-1:0]  core_op = '0;
  logic              core_valid = 1'b0;
  logic [OUT_WD-1:0] core_data = '0;
  logic              inj_valid = 1'b0;
  logic [OUT_WD-1:0] inj_data = '0;

  assign fact_out_valid = core_valid | inj_valid;
  assign fact_out_data  = inj_valid ? inj_data : core_data;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      core_pend  = 1'b0;
      core_valid = 1'b0;
    end else begin
      core_valid = 1'b0;
      if (core_pend) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_valid = 1'b1;
          core_data  = core_override ? core_val : fact_fn(core_op);
          core_pend  = 1'b0;
        end
      end
      if (fact_in_valid && core_en) begin
        core_pend = 1'b1;
        core_cnt  = core_lat;
        core_op   = fact_in_data;
      end
    end
  end

  // Issue monitor: counts request pulses, forbids back-to-back pulses and
  // pulses decided while the core reported busy.
  int   issue_cnt = 0;
  logic prev_fiv = 1'b0;
  always @(posedge clk) begin
    logic busy_before;
    busy_before = fact_out_busy;
    #1;
    if (fact_in_valid) begin
      issue_cnt++;
      check("issue_not_back_to_back", 32'(prev_fiv), 32'd0);
      check("issue_not_while_busy", 32'(busy_before), 32'd0);
    end
    prev_fiv = fact_in_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait (bounded) for rsp_valid; cyc = cycles after the issue cycle, or -1.
  task automatic wait_rsp(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = k;
        return;
      end
    end
  endtask

  // Push one operand into an idle, empty requester and check the T+2 issue.
  task automatic issue_one(input logic [IN_WD-1:0] op);
    check("cmd_ready_before_push", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("no_issue_at_T1", 32'(fact_in_valid), 32'd0);
    @(negedge clk);
    check("issue_at_T2", 32'(fact_in_valid), 32'd1);
    check("issue_data", 32'(fact_in_data), 32'(op));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drops_after_hs", 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [IN_WD-1:0]  op;
    int                lat;       // 0: core never answers
    logic [OUT_WD-1:0] val;       // value the core returns
    logic [OUT_WD-1:0] exp_data;
    logic              exp_to;
    logic              exp_mm;
    int                exp_cyc;   // rsp_valid cycle relative to issue cycle
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    int base;
    int idx;
    logic [OUT_WD-1:0] bl_data[4];
    logic [IN_WD-1:0]  bl_op[4];

    vecs[0] = '{3'd5, 3, 16'd120,  16'd120,  1'b0, 1'b0, 4};
    vecs[1] = '{3'd0, 1, 16'd1,    16'd1,    1'b0, 1'b0, 2};
    vecs[2] = '{3'd7, 5, 16'd5040, 16'd5040, 1'b0, 1'b0, 6};
    vecs[3] = '{3'd2, 8, 16'd2,    16'd2,    1'b0, 1'b0, 9};  // result on limit cycle wins
    vecs[4] = '{3'd3, 0, 16'd0,    16'd0,    1'b1, 1'b0, 9};  // timeout at I+TMO+1
    vecs[5] = '{3'd6, 7, 16'd700,  16'd700,  1'b0, 1'b1, 8};
    vecs[6] = '{3'd6, 2, 16'd720,  16'd720,  1'b0, 1'b0, 3};

    bl_op[0] = 3'd0; bl_data[0] = 16'd1;
    bl_op[1] = 3'd3; bl_data[1] = 16'd6;
    bl_op[2] = 3'd7; bl_data[2] = 16'd5040;
    bl_op[3] = 3'd4; bl_data[3] = 16'd24;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_fact_in_valid", 32'(fact_in_valid), 32'd0);
    check("rst_fact_in_data", 32'(fact_in_data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_operand", 32'(rsp_operand), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_err_spurious", 32'(err_spurious), 32'd0);
`ifdef FACT_REQ_CHECK_EN
    check("rst_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
`endif
    resetn = 1'b1;
    @(negedge clk);

    // Table of single transactions
    for (int v = 0; v < 7; v++) begin
      core_en       = (vecs[v].lat != 0);
      core_lat      = vecs[v].lat;
      core_override = 1'b1;
      core_val      = vecs[v].val;
      issue_one(vecs[v].op);
      wait_rsp(40, cyc);
      check("rsp_latency", 32'(cyc), 32'(vecs[v].exp_cyc));
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), 32'(vecs[v].exp_data));
      check("rsp_operand", 32'(rsp_operand), 32'(vecs[v].op));
      check("rsp_timeout", 32'(rsp_timeout), 32'(vecs[v].exp_to));
`ifdef FACT_REQ_CHECK_EN
      check("rsp_mismatch", 32'(rsp_mismatch), 32'(vecs[v].exp_mm));
`endif
      handshake();
    end
    check("err_clean_after_table", 32'(err_spurious), 32'd0);

    // Timeout followed by a late result, which must only flag err_spurious
    core_en = 1'b0;
    issue_one(3'd4);
    wait_rsp(40, cyc);
    check("late_timeout_latency", 32'(cyc), 32'(TMO + 1));
    check("late_timeout_flag", 32'(rsp_timeout), 32'd1);
    check("late_timeout_data", 32'(rsp_data), 32'd0);
    inj_valid = 1'b1;
    inj_data  = 16'd24;
    @(negedge clk);
    inj_valid = 1'b0;
    check("late_err_spurious", 32'(err_spurious), 32'd1);
    check("late_rsp_data_kept", 32'(rsp_data), 32'd0);
    check("late_rsp_valid_kept", 32'(rsp_valid), 32'd1);
    handshake();
    check("err_spurious_sticky", 32'(err_spurious), 32'd1);

    // Backlog: fill FIFO while the core is busy, then drain in order
    core_en       = 1'b1;
    core_override = 1'b0;
    core_lat      = 2;
    rsp_ready     = 1'b1;
    fact_out_busy = 1'b1;
    base          = issue_cnt;
    for (int i = 0; i < 4; i++) begin
      check("backlog_cmd_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_data  = bl_op[i];
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("backlog_full", 32'(cmd_ready), 32'd0);
    fact_out_busy = 1'b0;
    idx = 0;
    for (int k = 0; k < 80 && idx < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        check("backlog_rsp_data", 32'(rsp_data), 32'(bl_data[idx]));
        check("backlog_rsp_operand", 32'(rsp_operand), 32'(bl_op[idx]));
        idx++;
      end
    end
    check("backlog_rsp_count", 32'(idx), 32'd4);
    @(negedge clk);
    check("backlog_issue_count", 32'(issue_cnt - base), 32'd4);
    check("backlog_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Busy gating: nothing issues while busy; issue the cycle after the first
    // cycle busy is observed low (two cycles after the last busy cycle)
    fact_out_busy = 1'b1;
    base = issue_cnt;
    cmd_valid = 1'b1;
    cmd_data  = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_no_issue", 32'(issue_cnt - base), 32'd0);
    fact_out_busy = 1'b0;
    @(negedge clk);
    check("busy_release_issue", 32'(fact_in_valid), 32'd1);
    check("busy_release_data", 32'(fact_in_data), 32'd1);
    wait_rsp(20, cyc);
    check("busy_rsp_data", 32'(rsp_data), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Backpressure: response held stable, queued command waits for handshake
    core_lat = 3;
    issue_one(3'd5);
    cmd_valid = 1'b1;
    cmd_data  = 3'd2;
    @(negedge clk);
    cmd_data  = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(20, cyc);
    check("bp_rsp_data", 32'(rsp_data), 32'd120);
    core_en = 1'b0;
    base = issue_cnt;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", 32'(rsp_data), 32'd120);
      check("bp_hold_operand", 32'(rsp_operand), 32'd5);
      check("bp_hold_timeout", 32'(rsp_timeout), 32'd0);
    end
    check("bp_no_issue", 32'(issue_cnt - base), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_no_issue_R1", 32'(fact_in_valid), 32'd0);
    @(negedge clk);
    check("bp_issue_R2", 32'(fact_in_valid), 32'd1);
    check("bp_issue_data", 32'(fact_in_data), 32'd2);

    // Reset in the middle of WAIT with one command still queued
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_fact_in_valid", 32'(fact_in_valid), 32'd0);
    check("mid_rst_fact_in_data", 32'(fact_in_data), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    check("mid_rst_rsp_operand", 32'(rsp_operand), 32'd0);
    check("mid_rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("mid_rst_err_spurious", 32'(err_spurious), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    base = issue_cnt;
    repeat (6) @(negedge clk);
    check("post_rst_fifo_empty", 32'(issue_cnt - base), 32'd0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    // Recovery after reset
    core_en  = 1'b1;
    core_lat = 1;
    issue_one(3'd3);
    wait_rsp(20, cyc);
    check("recover_latency", 32'(cyc), 32'd2);
    check("recover_rsp_data", 32'(rsp_data), 32'd6);
    check("recover_rsp_operand", 32'(rsp_operand), 32'd3);
    handshake();
    check("recover_err_spurious", 32'(err_spurious), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_factorial_requester
